// File: rtl/dfr_mem_port_arbiter.sv
// Shares the B-port of the reservoir output BRAM among three requesters:
// reservoir writer (fixed top priority), matrix-multiplier reads and host
// debug/DMA access. Requesters 1 and 2 alternate round-robin, and either one
// preempts requester 0 once it has waited MAX_WAIT cycles. Memory-side
// signals are registered. A tag pipeline matching the BRAM latency routes
// each returned read to the requester that issued it.
module dfr_mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_WAIT     = 8
) (
  input  logic                  S_AXI_ACLK,
  input  logic                  S_AXI_ARESETN,
  input  logic                  wr0_req,
  input  logic [ADDR_WIDTH-1:0] wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  output logic                  wr0_gnt,
  input  logic                  rd1_req,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic                  rd1_gnt,
  output logic                  rd1_rvalid,
  input  logic                  h2_req,
  input  logic                  h2_we,
  input  logic [ADDR_WIDTH-1:0] h2_addr,
  input  logic [DATA_WIDTH-1:0] h2_wdata,
  output logic                  h2_gnt,
  output logic                  h2_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy
);

  localparam int unsigned WAIT_W   = 8;
  localparam int unsigned TAG_W    = 2;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [TAG_W-1:0]  TAG_NONE = 2'd0;
  localparam logic [TAG_W-1:0]  TAG_RD1  = 2'd1;
  localparam logic [TAG_W-1:0]  TAG_RD2  = 2'd2;

  logic                                  rr_sel2_q;  // 0: requester 1 preferred
  logic [WAIT_W-1:0]                     wait1_q;
  logic [WAIT_W-1:0]                     wait2_q;
  logic [READ_LATENCY-1:0][TAG_W-1:0]    tag_q;
  logic                                  starve1_c;
  logic                                  starve2_c;
  logic                                  gnt0_c;
  logic                                  gnt1_c;
  logic                                  gnt2_c;
  logic [TAG_W-1:0]                      issue_tag_c;

  assign starve1_c = rd1_req && (wait1_q == WAIT_MAX);
  assign starve2_c = h2_req  && (wait2_q == WAIT_MAX);

  // Single-winner arbitration: starving lower requester, then requester 0, then RR.
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    gnt2_c = 1'b0;
    if (starve1_c && starve2_c) begin
      gnt1_c = !rr_sel2_q;
      gnt2_c = rr_sel2_q;
    end else if (starve1_c) begin
      gnt1_c = 1'b1;
    end else if (starve2_c) begin
      gnt2_c = 1'b1;
    end else if (wr0_req) begin
      gnt0_c = 1'b1;
    end else if (rd1_req && h2_req) begin
      gnt1_c = !rr_sel2_q;
      gnt2_c = rr_sel2_q;
    end else if (rd1_req) begin
      gnt1_c = 1'b1;
    end else if (h2_req) begin
      gnt2_c = 1'b1;
    end
  end

  assign wr0_gnt = gnt0_c;
  assign rd1_gnt = gnt1_c;
  assign h2_gnt  = gnt2_c;

  // Tag of a read being issued this cycle; writes carry no tag.
  always_comb begin
    issue_tag_c = TAG_NONE;
    if (gnt1_c) begin
      issue_tag_c = TAG_RD1;
    end else if (gnt2_c && !h2_we) begin
      issue_tag_c = TAG_RD2;
    end
  end

  // Round-robin pointer flips to the other lower requester after it is served.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rr_sel2_q <= 1'b0;
    end else if (gnt1_c) begin
      rr_sel2_q <= 1'b1;
    end else if (gnt2_c) begin
      rr_sel2_q <= 1'b0;
    end
  end

  // Starvation counters: count denied cycles, saturate, clear on grant or idle.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      wait1_q <= '0;
      wait2_q <= '0;
    end else begin
      if (rd1_req && !gnt1_c) begin
        wait1_q <= (wait1_q == WAIT_MAX) ? wait1_q : wait1_q + WAIT_W'(1);
      end else begin
        wait1_q <= '0;
      end
      if (h2_req && !gnt2_c) begin
        wait2_q <= (wait2_q == WAIT_MAX) ? wait2_q : wait2_q + WAIT_W'(1);
      end else begin
        wait2_q <= '0;
      end
    end
  end

  // Issue stage: register the winner's access onto the BRAM port.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_en <= gnt0_c | gnt1_c | gnt2_c;
      mem_we <= gnt0_c | (gnt2_c & h2_we);
      if (gnt0_c) begin
        mem_addr <= wr0_addr;
        mem_din  <= wr0_data;
      end else if (gnt1_c) begin
        mem_addr <= rd1_addr;
      end else if (gnt2_c) begin
        mem_addr <= h2_addr;
        mem_din  <= h2_wdata;
      end
    end
  end

  // Read tag pipeline tracking the BRAM latency, plus registered valid strobes.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      tag_q      <= '0;
      rd1_rvalid <= 1'b0;
      h2_rvalid  <= 1'b0;
    end else begin
      tag_q[0] <= issue_tag_c;
      for (int i = int'(READ_LATENCY) - 1; i > 0; i--) begin
        tag_q[i] <= tag_q[i-1];
      end
      rd1_rvalid <= (tag_q[READ_LATENCY-1] == TAG_RD1);
      h2_rvalid  <= (tag_q[READ_LATENCY-1] == TAG_RD2);
    end
  end

  assign rdata = mem_dout;
  assign busy  = wr0_req | rd1_req | h2_req | (|tag_q);

endmodule
